// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard using
// the standard host request sequence: inhibit the clock, set up the start bit,
// release the clock, then drive each bit while the device clocks the frame.
// Finally, check the device ACK and wait for both lines to go idle.
//
// Ports:
//   CLK, RST          system clock, synchronous active-high reset
//   tx_data, tx_start byte to send and one-cycle request (ignored while busy)
//   busy              high from the accepted request through the done/err cycle
//   done, err         one-cycle completion / failure pulses (mutually exclusive)
//   KB_CLK_IN         raw PS/2 clock line
//   KB_DATA_IN        raw PS/2 data line
//   KB_CLK_OE         active-high pull-low enable for the clock line
//   KB_DATA_OE        active-high pull-low enable for the data line
//
// The receive path should ignore KB_CLK activity while busy=1, because the
// frame clocked out here uses the same physical clock line.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2048,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       KB_CLK_IN,
    input  logic       KB_DATA_IN,
    output logic       KB_CLK_OE,
    output logic       KB_DATA_OE
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int FLT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_TX,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t             state;
    logic               clk_s1, clk_s2, dat_s1, dat_s2;
    logic               clk_filt;
    logic [FLT_W-1:0]   filt_cnt;
    logic [7:0]         data_reg;
    logic [INH_W-1:0]   inh_cnt;
    logic [3:0]         bit_cnt;
    logic [WD_W-1:0]    wdog;
    logic               par;
    logic               fall_evt;

    assign par = ~^data_reg;

    // A fall happens on the cycle where the filtered level is about to flip from 1 to 0.
    assign fall_evt = clk_filt && !clk_s2 &&
                      (filt_cnt == FLT_W'(FILTER_CYCLES - 1));

    // Two-flop synchronizers plus a run-length filter on the clock line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            dat_s1   <= 1'b0;
            dat_s2   <= 1'b0;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= KB_CLK_IN;
            clk_s2 <= clk_s1;
            dat_s1 <= KB_DATA_IN;
            dat_s2 <= dat_s1;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FLT_W'(FILTER_CYCLES - 1)) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            data_reg   <= '0;
            inh_cnt    <= '0;
            bit_cnt    <= '0;
            wdog       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            KB_CLK_OE  <= 1'b0;
            KB_DATA_OE <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy is still high during the done/err cycle, so a
                    // request arriving in that cycle is dropped.
                    busy       <= 1'b0;
                    KB_CLK_OE  <= 1'b0;
                    KB_DATA_OE <= 1'b0;
                    if (tx_start && !busy) begin
                        data_reg  <= tx_data;
                        inh_cnt   <= '0;
                        busy      <= 1'b1;
                        KB_CLK_OE <= 1'b1;
                        state     <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        KB_DATA_OE <= 1'b1;   // start bit before clock release
                        state      <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    KB_CLK_OE <= 1'b0;
                    bit_cnt   <= '0;
                    wdog      <= WD_W'(TIMEOUT_CYCLES);
                    state     <= S_TX;
                end
                S_TX, S_ACK, S_RELEASE: begin
                    // Expiry is the decrement from 1 to 0; it overrides a same-cycle fall.
                    if (wdog == WD_W'(1)) begin
                        wdog       <= '0;
                        err        <= 1'b1;
                        KB_CLK_OE  <= 1'b0;
                        KB_DATA_OE <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        wdog <= wdog - 1'b1;
                        case (state)
                            S_TX: begin
                                if (fall_evt) begin
                                    wdog    <= WD_W'(TIMEOUT_CYCLES);
                                    bit_cnt <= bit_cnt + 1'b1;
                                    if (bit_cnt < 4'd8) begin
                                        KB_DATA_OE <= ~data_reg[bit_cnt[2:0]];
                                    end else if (bit_cnt == 4'd8) begin
                                        KB_DATA_OE <= ~par;
                                    end else begin
                                        KB_DATA_OE <= 1'b0;   // stop bit
                                        state      <= S_ACK;
                                    end
                                end
                            end
                            S_ACK: begin
                                if (fall_evt) begin
                                    wdog <= WD_W'(TIMEOUT_CYCLES);
                                    if (!dat_s2) begin
                                        state <= S_RELEASE;
                                    end else begin
                                        err   <= 1'b1;
                                        state <= S_IDLE;
                                    end
                                end
                            end
                            S_RELEASE: begin
                                if (clk_s2 && dat_s2) begin
                                    done  <= 1'b1;
                                    state <= S_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with an open-collector
// device model. The watchdog reload is shortened so the timeout case stays
// short. The device clock runs much faster than a real keyboard, but still
// much slower than the filter and synchronizer delay.
module tb_ps2_host_tx;

    localparam int T_OUT = 3000;
    localparam int HALF  = 40;
    localparam int INH   = 2048;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, err, KB_CLK_OE, KB_DATA_OE;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    wire clk_line  = dev_clk & ~KB_CLK_OE;
    wire data_line = dev_data & ~KB_DATA_OE;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .FILTER_CYCLES (8),
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .KB_CLK_IN (clk_line),
        .KB_DATA_IN(data_line),
        .KB_CLK_OE (KB_CLK_OE),
        .KB_DATA_OE(KB_DATA_OE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic        glitch;
        logic        dup;
        logic [10:0] frame;     // bit 0 = start, 1..8 data LSB first, 9 parity, 10 stop
        logic        exp_done;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          failures = 0;
    logic [10:0] frame;
    bit          dok, mok;
    int          inh_n, req_n, dp_n, ep_n, n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge CLK);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0;
    endtask

    // Keyboard model: it clocks the frame, samples data on each rising edge,
    // and optionally pulls data low for the ACK.
    task automatic dev_run(input bit ack, input bit glitch, input int max_falls,
                           output logic [10:0] fr, output bit ok);
        int w;
        fr = '0;
        ok = 1'b1;
        w  = 0;
        while (!(clk_line && !data_line) && w < 6000) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 6000) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) @(negedge CLK);
        fr[0] = data_line;
        for (int i = 1; i <= 11; i++) begin
            if (i > max_falls) return;
            if (i == 11 && ack) begin
                dev_data = 1'b0;
                repeat (5) @(negedge CLK);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge CLK);
            dev_clk = 1'b1;
            if (i <= 10) fr[i] = data_line;
            if (glitch && i == 3) begin
                repeat (10) @(negedge CLK);
                dev_clk = 1'b0;
                repeat (3) @(negedge CLK);
                dev_clk = 1'b1;
                repeat (HALF - 13) @(negedge CLK);
            end else begin
                repeat (HALF) @(negedge CLK);
            end
            if (i == 11) dev_data = 1'b1;
        end
    endtask

    task automatic mon(output int inh, output int req, output int dp, output int ep, output bit ok);
        int c;
        inh = 0; req = 0; dp = 0; ep = 0; c = 0;
        while (busy && c < 8000) begin
            if (KB_CLK_OE && !KB_DATA_OE) inh++;
            if (KB_CLK_OE && KB_DATA_OE)  req++;
            if (done) dp++;
            if (err)  ep++;
            @(negedge CLK);
            c++;
        end
        ok = (c < 8000);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        start_tx(v.data);
        fork
            dev_run(v.ack, v.glitch, 11, frame, dok);
            mon(inh_n, req_n, dp_n, ep_n, mok);
            if (v.dup) begin
                repeat (100) @(negedge CLK);
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(negedge CLK);
                tx_start = 1'b0;
            end
        join
        chk({tag, "_dev_ok"},  32'(dok), 32'd1);
        chk({tag, "_busy_drop"}, 32'(mok), 32'd1);
        chk({tag, "_frame"},   32'(frame), 32'(v.frame));
        chk({tag, "_inhibit"}, 32'(inh_n), 32'(INH));
        chk({tag, "_req"},     32'(req_n), 32'd1);
        chk({tag, "_done"},    32'(dp_n), 32'(v.exp_done));
        chk({tag, "_err"},     32'(ep_n), 32'(!v.exp_done));
        chk({tag, "_idle_out"}, 32'({busy, done, err, KB_CLK_OE, KB_DATA_OE}), 32'd0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 11'h7DA, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0, 11'h402, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 11'h600, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 11'h74A, 1'b0};
        vecs[4] = '{8'hED, 1'b1, 1'b1, 1'b0, 11'h7DA, 1'b1};
        vecs[5] = '{8'hED, 1'b1, 1'b0, 1'b1, 11'h7DA, 1'b1};

        repeat (4) @(negedge CLK);
        chk("reset_outs", 32'({busy, done, err, KB_CLK_OE, KB_DATA_OE}), 32'd0);
        RST = 1'b0;
        repeat (20) @(negedge CLK);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
            repeat (20) @(negedge CLK);
        end

        // The device never clocks, so the watchdog fires T_OUT cycles after TX entry.
        start_tx(8'h5A);
        n = 0;
        while (!(KB_CLK_OE && KB_DATA_OE) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk("to_req_seen", 32'(n < 5000), 32'd1);
        @(negedge CLK);
        n = 0;
        while (!err && n < T_OUT + 200) begin
            @(negedge CLK);
            n++;
        end
        chk("to_latency", 32'(n), 32'(T_OUT));
        chk("to_err_cycle", 32'({busy, KB_CLK_OE, KB_DATA_OE}), 32'b100);
        @(negedge CLK);
        chk("to_after", 32'({busy, err, KB_CLK_OE, KB_DATA_OE}), 32'd0);
        repeat (20) @(negedge CLK);

        // Reset after four bit-drive falls of 0x00, while the data line is held low.
        start_tx(8'h00);
        dev_run(1'b1, 1'b0, 4, frame, dok);
        chk("rst_pre", 32'({busy, KB_CLK_OE, KB_DATA_OE}), 32'b101);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid", 32'({busy, done, err, KB_CLK_OE, KB_DATA_OE}), 32'd0);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        run_vec(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
